// File: rtl/led_anim_sched.sv
// LED animation scheduler: prescaler, blink and head sequencing for walk-left/right, bounce and fill.
// Latency: mode entry from off is visible one cycle after the accepting edge; changes from an active mode apply at a step boundary.
// Backpressure: cfg_ready falls while a request is pending and rises again at the boundary that consumes it.
//
// Ports:
//   clk, rst (async, active-low)  | cfg_valid/cfg_mode/cfg_ready : mode request handshake
//   period, blink_en (live)       | leds, pos, busy, step        : registered animation outputs
module led_anim_sched #(
    parameter int N_LED      = 8,
    parameter int DIV_W      = 16,
    parameter int STEP_TICKS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    input  logic [2:0]                 cfg_mode,
    output logic                       cfg_ready,
    input  logic [DIV_W-1:0]           period,
    input  logic                       blink_en,
    output logic [N_LED-1:0]           leds,
    output logic [$clog2(N_LED)-1:0]   pos,
    output logic                       busy,
    output logic                       step
);
    localparam int POS_W = $clog2(N_LED);
    localparam int LVL_W = $clog2(N_LED + 1);
    localparam int SUB_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LED - 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_WALK_L = 3'd1,
        ST_WALK_R = 3'd2,
        ST_BOUNCE = 3'd3,
        ST_FILL   = 3'd4
    } state_t;

    // Undefined mode codes fall back to off.
    function automatic state_t mode_to_state(input logic [2:0] m);
        case (m)
            3'd1:    return ST_WALK_L;
            3'd2:    return ST_WALK_R;
            3'd3:    return ST_BOUNCE;
            3'd4:    return ST_FILL;
            default: return ST_OFF;
        endcase
    endfunction

    state_t             r_state,     w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt,   w_div_nxt;
    logic [SUB_W-1:0]   r_sub_cnt,   w_sub_nxt;
    logic               r_blink,     w_blink_nxt;
    logic               r_dir,       w_dir_nxt;      // bounce: 0 = up, 1 = down
    logic [LVL_W-1:0]   r_level,     w_level_nxt;
    logic [POS_W-1:0]   r_pos,       w_pos_nxt;
    logic               r_pend_vld,  w_pend_vld_nxt;
    logic [2:0]         r_pend_mode, w_pend_mode_nxt;
    logic [N_LED-1:0]   r_leds,      w_leds_nxt;
    logic               r_busy;
    logic               r_step;

    logic               w_tick;
    logic               w_bound;
    logic               w_xfer;
    logic               w_enter;
    logic [2:0]         w_enter_mode;
    logic               w_head;
    logic [POS_W-1:0]   w_pos_inc;
    logic [POS_W-1:0]   w_pos_dec;

    assign cfg_ready = ~r_pend_vld;
    assign w_xfer    = cfg_valid & cfg_ready;
    // >= so that a live decrease of period takes effect on the current count.
    assign w_tick    = (r_state != ST_OFF) && (r_div_cnt >= period);
    assign w_bound   = w_tick && (r_sub_cnt == SUB_W'(STEP_TICKS - 1));
    assign w_pos_inc = r_pos + POS_W'(1);
    assign w_pos_dec = r_pos - POS_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_OFF;
            r_div_cnt   <= '0;
            r_sub_cnt   <= '0;
            r_blink     <= 1'b0;
            r_dir       <= 1'b0;
            r_level     <= '0;
            r_pos       <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_mode <= 3'd0;
            r_leds      <= '0;
            r_busy      <= 1'b0;
            r_step      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_nxt;
            r_sub_cnt   <= w_sub_nxt;
            r_blink     <= w_blink_nxt;
            r_dir       <= w_dir_nxt;
            r_level     <= w_level_nxt;
            r_pos       <= w_pos_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_mode <= w_pend_mode_nxt;
            r_leds      <= w_leds_nxt;
            r_busy      <= (w_state_nxt != ST_OFF);
            r_step      <= w_bound;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div_cnt;
        w_sub_nxt       = r_sub_cnt;
        w_blink_nxt     = r_blink;
        w_dir_nxt       = r_dir;
        w_level_nxt     = r_level;
        w_pos_nxt       = r_pos;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_mode_nxt = r_pend_mode;
        w_enter         = 1'b0;
        w_enter_mode    = cfg_mode;

        if (r_state == ST_OFF) begin
            w_div_nxt   = '0;
            w_sub_nxt   = '0;
            w_blink_nxt = 1'b0;
            w_dir_nxt   = 1'b0;
            w_level_nxt = '0;
            w_pos_nxt   = '0;
            if (w_xfer) begin
                w_enter      = 1'b1;
                w_enter_mode = cfg_mode;
            end
        end else begin
            if (w_tick) begin
                w_div_nxt   = '0;
                w_blink_nxt = ~r_blink;
                w_sub_nxt   = w_bound ? '0 : r_sub_cnt + SUB_W'(1);
            end else begin
                w_div_nxt   = r_div_cnt + DIV_W'(1);
            end

            // A request landing on a boundary is only captured here; the
            // boundary below still sees the old (empty) pending flag.
            if (w_xfer) begin
                w_pend_vld_nxt  = 1'b1;
                w_pend_mode_nxt = cfg_mode;
            end

            if (w_bound) begin
                if (r_pend_vld) begin
                    w_pend_vld_nxt = 1'b0;
                    w_enter        = 1'b1;
                    w_enter_mode   = r_pend_mode;
                end else begin
                    case (r_state)
                        ST_WALK_L: w_pos_nxt = (r_pos == LAST_POS) ? '0 : w_pos_inc;
                        ST_WALK_R: w_pos_nxt = (r_pos == '0) ? LAST_POS : w_pos_dec;
                        ST_BOUNCE: begin
                            if (!r_dir) begin
                                w_pos_nxt = w_pos_inc;
                                if (w_pos_inc == LAST_POS) w_dir_nxt = 1'b1;
                            end else begin
                                w_pos_nxt = w_pos_dec;
                                if (w_pos_dec == '0) w_dir_nxt = 1'b0;
                            end
                        end
                        ST_FILL: begin
                            // Level N wraps to the empty frame; pos keeps the last head.
                            if (r_level == LVL_W'(N_LED)) begin
                                w_level_nxt = '0;
                            end else begin
                                w_level_nxt = r_level + LVL_W'(1);
                                w_pos_nxt   = r_level[POS_W-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        if (w_enter) begin
            w_state_nxt = mode_to_state(w_enter_mode);
            w_div_nxt   = '0;
            w_sub_nxt   = '0;
            w_blink_nxt = 1'b0;
            w_dir_nxt   = 1'b0;
            w_level_nxt = '0;
            w_pos_nxt   = '0;
            case (mode_to_state(w_enter_mode))
                ST_WALK_R: w_pos_nxt   = LAST_POS;
                ST_FILL:   w_level_nxt = LVL_W'(1);
                default:   ;
            endcase
        end
    end

    // Output logic: pattern for the upcoming cycle, registered in r_leds.
    always_comb begin
        w_leds_nxt = '0;
        w_head     = 1'b0;
        case (w_state_nxt)
            ST_WALK_L, ST_WALK_R, ST_BOUNCE: begin
                w_leds_nxt[w_pos_nxt] = 1'b1;
                w_head                = 1'b1;
            end
            ST_FILL: begin
                for (int i = 0; i < N_LED; i++) begin
                    w_leds_nxt[i] = (LVL_W'(i) < w_level_nxt);
                end
                w_head = (w_level_nxt != '0);
            end
            default: ;
        endcase
        if (blink_en && w_head) begin
            w_leds_nxt[w_pos_nxt] = w_blink_nxt;
        end
    end

    assign leds = r_leds;
    assign pos  = r_pos;
    assign busy = r_busy;
    assign step = r_step;

endmodule

// File: tb/tb_led_anim_sched.sv
module tb_led_anim_sched;
    localparam int N  = 8;
    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_mode = 3'd0;
    logic        cfg_ready;
    logic [15:0] period = 16'd0;
    logic        blink_en = 1'b0;
    logic [7:0]  leds;
    logic [2:0]  pos;
    logic        busy;
    logic        step;

    int n_cmp = 0;
    int n_err = 0;

    led_anim_sched #(.N_LED(N), .DIV_W(16), .STEP_TICKS(ST)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
        .cfg_ready(cfg_ready), .period(period), .blink_en(blink_en),
        .leds(leds), .pos(pos), .busy(busy), .step(step)
    );

    always #5 clk = ~clk;

    // Observed vector: {leds, pos, busy, step, cfg_ready}
    wire  [13:0] obs = {leds, pos, busy, step, cfg_ready};
    localparam logic [13:0] RST_VEC = {8'h00, 3'd0, 1'b0, 1'b0, 1'b1};

    // Reference model: mode, step index since entry, ticks since entry,
    // cycles since last tick, pending request.
    int   m_mode, m_idx, m_ticks, m_cnt, m_pmode;
    bit   m_pend;
    bit   m_step;
    logic [13:0] exp_vec;

    function automatic int dec_mode(input int m);
        return (m >= 1 && m <= 4) ? m : 0;
    endfunction

    function automatic bit model_bound_next();
        return (m_mode != 0) && (m_cnt >= int'(period)) && (((m_ticks + 1) % ST) == 0);
    endfunction

    task automatic model_expect();
        logic [7:0] l;
        int p, lvl, k;
        bit head;
        l = 8'h00; p = 0; head = 1'b0;
        case (m_mode)
            1: begin p = m_idx % N;           l = 8'(1 << p); head = 1'b1; end
            2: begin p = N - 1 - (m_idx % N); l = 8'(1 << p); head = 1'b1; end
            3: begin
                k = m_idx % (2 * N - 2);
                p = (k < N) ? k : (2 * N - 2 - k);
                l = 8'(1 << p); head = 1'b1;
            end
            4: begin
                lvl  = (m_idx + 1) % (N + 1);
                p    = (lvl == 0) ? N - 1 : lvl - 1;
                l    = 8'((1 << lvl) - 1);
                head = (lvl != 0);
            end
            default: ;
        endcase
        if (blink_en && head) l[p] = 1'(m_ticks % 2);
        exp_vec = {l, 3'(p), (m_mode != 0), m_step, !m_pend};
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_ticks = 0; m_cnt = 0; m_pmode = 0;
        m_pend = 1'b0; m_step = 1'b0;
        model_expect();
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_edge();
        bit xfer;
        m_step = 1'b0;
        if (m_mode == 0) begin
            m_cnt = 0; m_ticks = 0;
            if (cfg_valid) begin m_mode = dec_mode(int'(cfg_mode)); m_idx = 0; end
        end else begin
            xfer = cfg_valid && !m_pend;
            if (m_cnt >= int'(period)) begin
                m_cnt = 0;
                m_ticks++;
                if ((m_ticks % ST) == 0) begin
                    m_step = 1'b1;
                    if (m_pend) begin
                        m_mode = dec_mode(m_pmode); m_idx = 0; m_ticks = 0; m_pend = 1'b0;
                    end else begin
                        m_idx++;
                    end
                end
            end else begin
                m_cnt++;
            end
            if (xfer) begin m_pend = 1'b1; m_pmode = int'(cfg_mode); end
        end
        model_expect();
    endtask

    task automatic clk_cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; cfg_valid = 1'b0; cfg_mode = 3'd0; period = 16'd0; blink_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic send(input logic [2:0] m);
        cfg_valid = 1'b1; cfg_mode = m;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs !== exp_vec) begin
            n_err++; $display("FAIL reset_state got=%h exp=%h", obs, exp_vec);
        end
        send(3'd1); clk_cycle(); cfg_valid = 1'b0;
        repeat (9) clk_cycle();
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== RST_VEC) begin
            n_err++; $display("FAIL reset_async got=%h exp=%h", obs, RST_VEC);
        end
        do_reset();
        repeat (3) clk_cycle();
        n_cmp++;
        if (obs !== exp_vec) begin
            n_err++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec);
        end
    endtask

    task automatic test_walk_left();
        do_reset();
        send(3'd1); clk_cycle(); cfg_valid = 1'b0;
        n_cmp++;
        if (leds !== 8'h01) begin
            n_err++; $display("FAIL walk_entry got=%h exp=01", leds);
        end
        for (int c = 0; c < 40; c++) begin
            clk_cycle();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL walk_l cyc=%0d got=%h exp=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        send(3'd3); clk_cycle(); cfg_valid = 1'b0;
        for (int c = 0; c < 70; c++) begin
            clk_cycle();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL bounce cyc=%0d got=%h exp=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        send(3'd4); clk_cycle(); cfg_valid = 1'b0;
        for (int c = 0; c < 45; c++) begin
            clk_cycle();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL fill cyc=%0d got=%h exp=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_mode_change();
        do_reset();
        send(3'd1); clk_cycle(); cfg_valid = 1'b0;
        repeat (12) clk_cycle();
        n_cmp++;
        if (pos !== 3'd3) begin
            n_err++; $display("FAIL chg_pos got=%0d exp=3", pos);
        end
        send(3'd2); clk_cycle(); cfg_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            clk_cycle();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL chg_walk_r cyc=%0d got=%h exp=%h", c, obs, exp_vec);
            end
        end
        send(3'd0); clk_cycle(); cfg_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            clk_cycle();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL chg_off cyc=%0d got=%h exp=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_blink_collision();
        bit found;
        do_reset();
        period = 16'd1; blink_en = 1'b1;
        send(3'd1); clk_cycle(); cfg_valid = 1'b0;
        for (int c = 0; c < 18; c++) begin
            clk_cycle();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL blink cyc=%0d got=%h exp=%h", c, obs, exp_vec);
            end
        end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (model_bound_next()) found = 1'b1;
            else clk_cycle();
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL collide_wait got=timeout exp=boundary");
        end
        send(3'd2);
        for (int c = 0; c < 24; c++) begin
            clk_cycle();
            cfg_valid = 1'b0;
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL collide cyc=%0d got=%h exp=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_mode  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) period = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) blink_en = ~blink_en;
            clk_cycle();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, exp_vec);
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_walk_left();
        test_bounce();
        test_fill();
        test_mode_change();
        test_blink_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_anim_sched.md
# led_anim_sched

Animation scheduler for the 8-LED strip. It owns the step-rate prescaler, blink generation and the position sequencing for four animation modes (walk-left, walk-right, bounce, fill), and drives the LED bus directly. Mode changes arrive over a valid/ready handshake and take effect on a step boundary, so patterns never tear mid-step.

## Interface
- `N_LED`, default 8: number of LEDs; must be ≥2.
- `DIV_W`, default 16: width of the prescaler period.
- `STEP_TICKS`, default 4: prescaler ticks per animation step; must be ≥1.
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `cfg_valid`, input, 1: mode request valid.
- `cfg_mode`, input, 3: requested mode.
  - 0 = off, 1 = walk_l, 2 = walk_r, 3 = bounce, 4 = fill.
  - 5–7 are treated as off.
- `cfg_ready`, output, 1: request can be accepted this cycle.
- `period`, input, DIV_W: prescaler tick every period+1 cycles; sampled live.
- `blink_en`, input, 1: head LED shows the blink phase instead of a steady 1; sampled live.
- `leds`, output, N_LED: registered LED drive.
- `pos`, output, $clog2(N_LED): current head index.
- `busy`, output, 1: high in any mode except off.
- `step`, output, 1: one-cycle pulse on every step boundary.

## Operation
- **Reset values:** state OFF; `leds`=0, `pos`=0, `step`=0, `busy`=0, `cfg_ready`=1; prescaler, tick counter, blink, direction, fill level and pending flag all 0.
- **States:** OFF, WALK_L, WALK_R, BOUNCE, FILL.
- **Prescaler:**
  - `div_cnt` increments each cycle in the active states.
  - When `div_cnt` ≥ `period`: emit a tick and set `div_cnt` to 0. The ≥ comparison makes a live decrease of `period` take effect immediately.
  - `period`=0 gives a tick every cycle.
  - `div_cnt` is held at 0 in OFF.
- **Step:** `sub_cnt` counts ticks 0..STEP_TICKS-1. A tick with `sub_cnt`=STEP_TICKS-1 is a step boundary: pulse `step`, set `sub_cnt` to 0, then apply the pending mode or advance the position.
- **Blink:** the blink flag toggles on every tick in the active states. It is cleared on every mode entry and in OFF.
- **Entry positions:**
  - WALK_L: `pos`=0.
  - WALK_R: `pos`=N_LED-1.
  - BOUNCE: `pos`=0, direction up.
  - FILL: level=1, `pos`=0.
- **Advance:**
  - WALK_L: `pos`+1, wrapping N_LED-1→0.
  - WALK_R: `pos`-1, wrapping 0→N_LED-1.
  - BOUNCE: moves by ±1. Direction flips to down on reaching N_LED-1 and to up on reaching 0. End positions are not repeated (…6,7,6…).
  - FILL: level cycles 1..N_LED, then 0, then 1. `pos`=level-1; `pos` holds its value while level=0.
- **Pattern:**
  - Walk and bounce: one-hot at `pos`.
  - Fill: bits [level-1:0] set. Level 0 shows all off with no head.
  - When `blink_en`=1, the head bit `leds[pos]` is replaced by the blink flag. Fill at level 0 is unaffected.
- **Handshake:** a transfer occurs when `cfg_valid` && `cfg_ready`.
  - In OFF: the mode loads at that edge. Entry pattern, cleared counters and `busy` are visible the next cycle. Mode 0 leaves the block in OFF.
  - In an active state: the mode is stored as pending and `cfg_ready`=0 until the next step boundary.
  - At the step boundary the pending mode is entered instead of advancing, and `step` still pulses.
  - A pending mode 0 returns the block to OFF with `leds`=0 and `pos`=0.
  - Re-requesting the current mode restarts it at its entry position.
- **Simultaneous request and step boundary:** the request is captured as pending and this boundary advances the old mode. The request applies at the following boundary.
- **Reset mid-operation:** immediate return to the reset values; any pending request is dropped.

## Timing
- `leds`, `pos`, `busy` and `step` are registered; there is no combinational input-to-output path except `cfg_ready`, which is derived from registers only.
- First step after entry: STEP_TICKS×(`period`+1) cycles after the entry edge. Every later step follows at the same interval while `period` is constant.
- Blink half-period: `period`+1 cycles.
- Mode-change latency from an active state: at most one step interval after acceptance, plus one step if the request coincides with a boundary.

## Test plan
- **Reset:** assert `rst`=0 mid-walk → `leds`=0x00, `pos`=0, `busy`=0, `cfg_ready`=1, `step`=0 asynchronously.
- **Walk-left:** `period`=0, STEP_TICKS=4, `blink_en`=0, request mode 1 from OFF → `leds`=0x01 next cycle, then 0x02 after 4 cycles, …, 0x80 → 0x01 wrap; `step` pulses every 4 cycles.
- **Bounce:** mode 3 → `pos` sequence 0,1,…,7,6,…,0,1 with no duplicate at either end.
- **Fill:** mode 4 → `leds` 0x01, 0x03, 0x07, …, 0xFF, 0x00, 0x01.
- **Mode change mid-walk:** request mode 2 while walk_l is at `pos`=3 → `cfg_ready`=0 until the next boundary; at that boundary `leds`=0x80 and `step`=1. Then request mode 0 → `leds`=0x00, `busy`=0 at the following boundary.
- **Blink and boundary collision:** `blink_en`=1, `period`=1, mode 1 → `leds` 0x00 for 2 cycles, then 0x01 for 2 cycles, alternating. Also assert `cfg_valid` in the same cycle as a step boundary → the old mode advances once more before the new mode is entered.
